// File: rtl/alu_packet_parser_if.sv
// Byte-stream bus of the UART ALU command parser: receive side (from the UART
// receiver), transmit side (toward the UART transmitter) and status flags.
interface alu_packet_parser_if;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       err_o;
    logic       busy_o;

    // Parser side.
    modport slave (
        input  rx_data_i, rx_valid_i, tx_ready_i,
        output rx_ready_o, tx_data_o, tx_valid_o, err_o, busy_o
    );

    // Environment side: byte source, response sink, status observer.
    modport master (
        output rx_data_i, rx_valid_i, tx_ready_i,
        input  rx_ready_o, tx_data_o, tx_valid_o, err_o, busy_o
    );
endinterface

// File: rtl/alu_packet_parser.sv
// Framed command parser for the UART ALU. Packets are
// opcode, reserved, LEN[7:0], LEN[15:8], payload (LEN-4 bytes).
// Echo returns the payload; add sums 32-bit little-endian operands and
// returns the 32-bit sum LSB first. Bad packets pulse err_o and are drained.
module alu_packet_parser (
    input  logic                clk_i,
    input  logic                rst_ni,
    alu_packet_parser_if.slave  bus
);

    localparam logic [7:0] ECHO_OP = 8'hEC;
    localparam logic [7:0] ADD_OP  = 8'h10;

    typedef enum logic [2:0] {
        S_OPCODE,
        S_RSVD,
        S_LEN_LO,
        S_LEN_HI,
        S_ECHO,
        S_ADD_RX,
        S_ADD_TX,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] cnt_q, cnt_d;      // payload bytes still expected
    logic [31:0] acc_q, acc_d;      // add accumulator
    logic [23:0] opnd_q, opnd_d;    // first three bytes of the operand in flight
    logic [2:0]  tx_idx_q, tx_idx_d; // sum bytes already loaded into the tx register
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        err_q, err_d;

    logic        rx_ready;
    logic        rx_fire;
    logic        tx_free;
    logic [15:0] len_full;
    logic [31:0] acc_sum;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        return w[8*idx +: 8];
    endfunction

    // Shared datapath terms: tx slot availability, completed LEN, running sum.
    assign tx_free  = !tx_valid_q || bus.tx_ready_i;
    assign len_full = {bus.rx_data_i, len_lo_q};
    assign acc_sum  = acc_q + {bus.rx_data_i, opnd_q};
    assign rx_fire  = bus.rx_valid_i && rx_ready;

    // Receive readiness: header, add payload and drain never stall; echo waits
    // for the tx slot; the add response blocks input entirely.
    always_comb begin
        unique case (state_q)
            S_ECHO:   rx_ready = tx_free;
            S_ADD_TX: rx_ready = 1'b0;
            default:  rx_ready = 1'b1;
        endcase
    end

    // Next-state and datapath decisions for the packet FSM.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves a latch behind.
        state_d    = state_q;
        opcode_d   = opcode_q;
        len_lo_d   = len_lo_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q && !bus.tx_ready_i; // a handshake empties the slot
        err_d      = 1'b0;

        unique case (state_q)
            S_OPCODE: begin
                if (rx_fire) begin
                    opcode_d = bus.rx_data_i;
                    acc_d    = '0;
                    state_d  = S_RSVD;
                end
            end

            S_RSVD: begin
                if (rx_fire) state_d = S_LEN_LO;
            end

            S_LEN_LO: begin
                if (rx_fire) begin
                    len_lo_d = bus.rx_data_i;
                    state_d  = S_LEN_HI;
                end
            end

            S_LEN_HI: begin
                if (rx_fire) begin
                    cnt_d    = len_full - 16'd4;
                    opnd_d   = '0;
                    tx_idx_d = '0;
                    if (len_full < 16'd4) begin
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_OPCODE;
                    end else if (len_full == 16'd4) begin
                        if (opcode_q == ADD_OP) begin
                            state_d = S_ADD_TX;
                            if (tx_free) begin
                                tx_data_d  = byte_of(acc_q, 2'd0);
                                tx_valid_d = 1'b1;
                                tx_idx_d   = 3'd1;
                            end
                        end else begin
                            // Empty echo is silent; an empty unknown packet has nothing to drain.
                            err_d   = (opcode_q != ECHO_OP);
                            state_d = S_OPCODE;
                        end
                    end else if (opcode_q == ECHO_OP) begin
                        state_d = S_ECHO;
                    end else if (opcode_q == ADD_OP && len_full[1:0] == 2'd0) begin
                        // (LEN-4) % 4 == LEN % 4
                        state_d = S_ADD_RX;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end

            S_ECHO: begin
                if (rx_fire) begin
                    tx_data_d  = bus.rx_data_i;
                    tx_valid_d = 1'b1;
                    cnt_d      = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = S_OPCODE;
                end
            end

            S_ADD_RX: begin
                if (rx_fire) begin
                    cnt_d = cnt_q - 16'd1;
                    // Payload is a multiple of 4, so cnt%4 == 1 marks an operand's MSB.
                    if (cnt_q[1:0] == 2'd1) begin
                        acc_d  = acc_sum;
                        opnd_d = '0;
                    end else begin
                        opnd_d = {bus.rx_data_i, opnd_q[23:8]};
                    end
                    if (cnt_q == 16'd1) begin
                        state_d  = S_ADD_TX;
                        tx_idx_d = '0;
                        if (tx_free) begin
                            tx_data_d  = byte_of(acc_sum, 2'd0);
                            tx_valid_d = 1'b1;
                            tx_idx_d   = 3'd1;
                        end
                    end
                end
            end

            S_ADD_TX: begin
                if (tx_free) begin
                    if (tx_idx_q != 3'd4) begin
                        tx_data_d  = byte_of(acc_q, tx_idx_q[1:0]);
                        tx_valid_d = 1'b1;
                        tx_idx_d   = tx_idx_q + 3'd1;
                    end else begin
                        state_d = S_OPCODE;
                    end
                end
            end

            S_DRAIN: begin
                if (rx_fire) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = S_OPCODE;
                end
            end

            default: state_d = S_OPCODE;
        endcase
    end

    // State and datapath registers; reset abandons any partial packet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_OPCODE;
            opcode_q   <= '0;
            len_lo_q   <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            tx_idx_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register samples pre-edge values.
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            len_lo_q   <= len_lo_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            tx_idx_q   <= tx_idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.rx_ready_o = rx_ready;
    assign bus.tx_data_o  = tx_data_q;
    assign bus.tx_valid_o = tx_valid_q;
    assign bus.err_o      = err_q;
    assign bus.busy_o     = (state_q != S_OPCODE);

endmodule

// File: tb/tb_alu_packet_parser.sv
// Directed bench for alu_packet_parser: echo, add, wrap, malformed packets,
// backpressure and reset during the add response.
module tb_alu_packet_parser;

    typedef logic [7:0] byte_q_t[$];

    logic clk;
    logic rst_n;

    alu_packet_parser_if bus ();

    alu_packet_parser dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations gathered on the falling edge, away from the active edge.
    byte_q_t txq;
    time     tx_t[$];
    int      err_cnt  = 0;
    int      stall    = 0;
    int      stab_err = 0;
    logic    prev_pend = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend && (!bus.tx_valid_o || bus.tx_data_o !== prev_data)) stab_err++;
            if (bus.tx_valid_o && bus.tx_ready_i) begin
                txq.push_back(bus.tx_data_o);
                tx_t.push_back($time);
            end
            if (bus.err_o) err_cnt++;
            if (bus.rx_valid_i && !bus.rx_ready_o) stall++;
            prev_pend = bus.tx_valid_o && !bus.tx_ready_i;
            prev_data = bus.tx_data_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte and return 1 ns after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.rx_ready_o) break;
            n++;
            if (n > 200) begin
                n_tests++;
                n_fail++;
                $error("FAIL rx_accept_timeout: byte %0h not accepted within 200 cycles", b);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input byte_q_t p);
        foreach (p[i]) send_byte(p[i]);
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx(input int target);
        int k = 0;
        while (txq.size() < target && k < 200) begin
            @(posedge clk);
            k++;
        end
        idle(2);
    endtask

    task automatic clear_obs();
        txq.delete();
        tx_t.delete();
        err_cnt = 0;
        stall   = 0;
    endtask

    initial begin
        byte_q_t p;

        bus.rx_data_i  = '0;
        bus.rx_valid_i = 1'b0;
        bus.tx_ready_i = 1'b1;
        rst_n          = 1'b0;

        // Reset values
        #12;
        check("rst_rx_ready", bus.rx_ready_o, 1);
        check("rst_tx_valid", bus.tx_valid_o, 0);
        check("rst_tx_data",  bus.tx_data_o,  8'h00);
        check("rst_err",      bus.err_o,      0);
        check("rst_busy",     bus.busy_o,     0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Echo EC 00 06 00 48 69
        clear_obs();
        send_byte(8'hEC);
        check("echo_busy_rise", bus.busy_o, 1);
        send_byte(8'h00);
        send_byte(8'h06);
        send_byte(8'h00);
        send_byte(8'h48);
        check("echo_lat_valid", bus.tx_valid_o, 1);
        check("echo_lat_data",  bus.tx_data_o,  8'h48);
        send_byte(8'h69);
        bus.rx_valid_i = 1'b0;
        check("echo_busy_fall", bus.busy_o,    0);
        check("echo_last_data", bus.tx_data_o, 8'h69);
        wait_tx(2);
        check("echo_count", txq.size(), 2);
        check("echo_b0",    txq[0],     8'h48);
        check("echo_b1",    txq[1],     8'h69);
        check("echo_err",   err_cnt,    0);

        // Add 1 + 2
        clear_obs();
        p = {8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        check("add_lat_valid", bus.tx_valid_o, 1);
        check("add_lat_data",  bus.tx_data_o,  8'h03);
        wait_tx(4);
        check("add_count", txq.size(), 4);
        check("add_word",  {txq[3], txq[2], txq[1], txq[0]}, 32'h0000_0003);
        check("add_back_to_back", 32'(tx_t[3] - tx_t[0]), 30);
        check("add_busy_after", bus.busy_o, 0);

        // Add wraps modulo 2^32
        clear_obs();
        p = {8'h10, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        wait_tx(4);
        check("wrap_count", txq.size(), 4);
        check("wrap_word",  {txq[3], txq[2], txq[1], txq[0]}, 32'h0000_0001);
        check("wrap_err",   err_cnt, 0);

        // Unknown opcode, payload drained
        clear_obs();
        p = {8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        send_pkt(p);
        idle(3);
        check("unk_err",  err_cnt,    1);
        check("unk_tx",   txq.size(), 0);
        check("unk_busy", bus.busy_o, 0);

        // Add with misaligned length: 3 payload bytes drained
        clear_obs();
        p = {8'h10, 8'h00, 8'h07, 8'h00};
        send_pkt(p);
        check("mis_err_pulse", bus.err_o,  1);
        check("mis_drain_busy", bus.busy_o, 1);
        p = {8'h01, 8'h02, 8'h03};
        send_pkt(p);
        check("mis_drain_done", bus.busy_o, 0);
        idle(3);
        check("mis_err", err_cnt,    1);
        check("mis_tx",  txq.size(), 0);

        // Framing preserved afterwards
        clear_obs();
        p = {8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
        send_pkt(p);
        wait_tx(1);
        check("refr_count", txq.size(), 1);
        check("refr_b0",    txq[0],     8'h7E);

        // LEN < 4
        clear_obs();
        p = {8'hEC, 8'h00, 8'h03, 8'h00};
        send_pkt(p);
        check("short_err",  bus.err_o,  1);
        check("short_busy", bus.busy_o, 0);
        idle(1);
        check("short_err_one_cycle", bus.err_o, 0);
        idle(2);
        check("short_err_cnt", err_cnt,    1);
        check("short_tx",      txq.size(), 0);

        // Backpressure during an 8-byte echo
        clear_obs();
        stab_err = 0;
        p = {8'hEC, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        fork
            send_pkt(p);
            begin
                repeat (6) @(posedge clk);
                #1 bus.tx_ready_i = 1'b0;
                repeat (10) @(posedge clk);
                #1 bus.tx_ready_i = 1'b1;
            end
        join
        wait_tx(8);
        check("bp_stall_cycles", stall,      10);
        check("bp_count",        txq.size(), 8);
        for (int i = 0; i < 8 && i < txq.size(); i++) check($sformatf("bp_b%0d", i), txq[i], i);
        check("bp_tx_hold", stab_err, 0);

        // Reset in the middle of an add response
        clear_obs();
        bus.tx_ready_i = 1'b0;
        p = {8'h10, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_pkt(p);
        check("rst_mid_first",    bus.tx_data_o,  8'h01);
        check("rst_mid_rx_block", bus.rx_ready_o, 0);
        bus.tx_ready_i = 1'b1;
        idle(2);
        bus.tx_ready_i = 1'b0;
        check("rst_mid_pending", bus.tx_data_o, 8'h03);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx_valid", bus.tx_valid_o, 0);
        check("rst_mid_tx_data",  bus.tx_data_o,  8'h00);
        check("rst_mid_busy",     bus.busy_o,     0);
        check("rst_mid_sent",     txq.size(),     2);
        check("rst_mid_bytes",    {txq[1], txq[0]}, 16'h0201);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.tx_ready_i = 1'b1;
        clear_obs();
        p = {8'hEC, 8'h00, 8'h05, 8'h00, 8'h33};
        send_pkt(p);
        wait_tx(1);
        check("post_rst_count", txq.size(), 1);
        check("post_rst_b0",    txq[0],     8'h33);
        check("post_rst_err",   err_cnt,    0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
